memory_arbitrated_burst: RTL

//  Parametrised on-chip RAM with two request channels sharing one array.

---
 rtl/memory_arbitrated_burst.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/memory_arbitrated_burst.sv
// Shared on-chip RAM serving a single-beat CPU port (A) and a bursting DMA port (B).
// Round-robin arbitration between the two ports. Read data is registered, and
// burst addresses wrap around modulo the memory depth.
module memory_arbitrated_burst #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_out,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [DATA_W-1:0]  a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [DATA_W-1:0]  a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [ADDR_W-1:0]  b_addr,
  input  logic [BURST_W-1:0] b_len,
  input  logic               b_wvalid,
  input  logic [DATA_W-1:0]  b_wdata,
  output logic               b_wready,
  output logic               b_rvalid,
  output logic [DATA_W-1:0]  b_rdata,
  output logic               b_busy,
  output logic               b_done
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {IDLE, A_ACC, B_BURST, B_DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [BURST_W-1:0] cnt;
  logic               we_b;
  logic               last_gnt_b;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               gnt_a;
  logic               gnt_b;
  logic               b_beat;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [DATA_W-1:0]  mem_wdata;

  // Arbitration: the port that did not win last time takes a tie
  always_comb begin
    gnt_a = (state == IDLE) && a_req && (!b_req || last_gnt_b);
    gnt_b = (state == IDLE) && b_req && (!a_req || !last_gnt_b);
  end

  assign b_wready = (state == B_BURST) && we_b;

  // A burst beat advances on every read cycle, or on a write cycle carrying data
  assign b_beat = (state == B_BURST) && (!we_b || b_wvalid);

  // Single write port into the array; writes are suppressed while reset is held
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = a_addr;
    mem_wdata = a_wdata;
    if (!rst_out) begin
      if (gnt_a && a_we) begin
        mem_we = 1'b1;
      end else if (b_wready && b_wvalid) begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = b_wdata;
      end
    end
  end

  // Memory array: no reset, contents survive rst_out
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered handshake and read-data outputs
  always_ff @(posedge clk or posedge rst_out) begin
    if (rst_out) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      we_b       <= 1'b0;
      last_gnt_b <= 1'b1;
      a_gnt      <= 1'b0;
      a_rvalid   <= 1'b0;
      a_rdata    <= '0;
      b_rvalid   <= 1'b0;
      b_rdata    <= '0;
      b_busy     <= 1'b0;
      b_done     <= 1'b0;
    end else begin
      a_gnt    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      b_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_a) begin
            state      <= A_ACC;
            last_gnt_b <= 1'b0;
            a_gnt      <= 1'b1;
            if (!a_we) begin
              a_rvalid <= 1'b1;
              a_rdata  <= mem[a_addr];
            end
          end else if (gnt_b) begin
            last_gnt_b <= 1'b1;
            ptr        <= b_addr;
            cnt        <= b_len;
            we_b       <= b_we;
            if (b_len == '0) begin
              state  <= B_DONE;
              b_done <= 1'b1;
            end else begin
              state  <= B_BURST;
              b_busy <= 1'b1;
            end
          end
        end
        A_ACC: begin
          state <= IDLE;
        end
        B_BURST: begin
          if (b_beat) begin
            ptr <= ptr + ADDR_W'(1);
            cnt <= cnt - BURST_W'(1);
            if (!we_b) begin
              b_rdata  <= mem[ptr];
              b_rvalid <= 1'b1;
            end
            if (cnt == BURST_W'(1)) begin
              state  <= B_DONE;
              b_done <= 1'b1;
              b_busy <= 1'b0;
            end
          end
        end
        B_DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
